pht_port_scheduler: RTL and testbench

- Owns the single-ported pattern history table (PHT) SRAM of 2-bit saturating counters that backs the dynamic branch predictor.
- Arbitrates that one port between decode-stage prediction lookups and execute-stage training updates.
- Buffers execute feedback in a small FIFO and performs each update as a read-modify-write pair.
- Initialises the whole table after reset.
- Sits inside branch_controller, between the decode request path, the execute feedback path and the PHT macro.

---
 rtl/pht_port_scheduler.sv | 169 ++++++++++++++++
 tb/tb_pht_port_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pht_port_scheduler.sv
// Single-port PHT arbiter: decode predictions vs. buffered execute training updates.
// Clears the table to weakly-not-taken after reset, then serves one access per cycle.
module pht_port_scheduler #(
    parameter int ADDR_WIDTH   = 32,
    parameter int INDEX_WIDTH  = 6,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    input  logic [ADDR_WIDTH-1:0]  req_pc,
    output logic                   req_ready,
    output logic                   resp_valid,
    output logic                   resp_prediction,
    input  logic                   fb_valid,
    input  logic [ADDR_WIDTH-1:0]  fb_pc,
    input  logic                   fb_outcome,
    output logic                   fb_ready,
    output logic                   pht_en,
    output logic                   pht_we,
    output logic [INDEX_WIDTH-1:0] pht_addr,
    output logic [1:0]             pht_wdata,
    input  logic [1:0]             pht_rdata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_UPD_WR} state_e;

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] init_idx_q, init_idx_d;
    logic [INDEX_WIDTH-1:0] upd_idx_q, upd_idx_d;
    logic                   upd_out_q, upd_out_d;
    logic [STV_W-1:0]       starve_q, starve_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [INDEX_WIDTH-1:0] fifo_idx_q [FIFO_DEPTH];
    logic [INDEX_WIDTH-1:0] fifo_idx_d [FIFO_DEPTH];
    logic                   fifo_out_q [FIFO_DEPTH];
    logic                   fifo_out_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   fifo_empty, fifo_full, push, pop;
    logic                   en_c, we_c;
    logic [INDEX_WIDTH-1:0] addr_c;
    logic [1:0]             wdata_c, sat_val;
    logic [INDEX_WIDTH-1:0] req_idx, fb_idx;
    logic                   unused_pc_bits;

    assign req_idx = req_pc[INDEX_WIDTH+1:2];
    assign fb_idx  = fb_pc[INDEX_WIDTH+1:2];
    assign unused_pc_bits = ^{req_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], req_pc[1:0],
                              fb_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], fb_pc[1:0]};

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fb_ready   = (state_q != ST_INIT) && !fifo_full;
    assign push       = fb_valid && fb_ready;

    always_comb begin
        if (upd_out_q) sat_val = (pht_rdata == 2'b11) ? 2'b11 : pht_rdata + 2'd1;
        else           sat_val = (pht_rdata == 2'b00) ? 2'b00 : pht_rdata - 2'd1;
    end

    always_comb begin
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        upd_idx_d    = upd_idx_q;
        upd_out_d    = upd_out_q;
        starve_d     = starve_q;
        resp_valid_d = 1'b0;
        pop          = 1'b0;
        req_ready    = 1'b0;
        en_c         = 1'b0;
        we_c         = 1'b0;
        addr_c       = '0;
        wdata_c      = 2'b00;
        case (state_q)
            ST_INIT: begin
                en_c       = 1'b1;
                we_c       = 1'b1;
                addr_c     = init_idx_q;
                wdata_c    = 2'b01;
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == LAST_IDX) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!fifo_empty && (!req_valid || starve_q == STV_W'(STARVE_LIMIT))) begin
                    en_c      = 1'b1;
                    addr_c    = fifo_idx_q[rd_ptr_q];
                    upd_idx_d = fifo_idx_q[rd_ptr_q];
                    upd_out_d = fifo_out_q[rd_ptr_q];
                    pop       = 1'b1;
                    starve_d  = '0;
                    state_d   = ST_UPD_WR;
                end else if (req_valid) begin
                    req_ready    = 1'b1;
                    en_c         = 1'b1;
                    addr_c       = req_idx;
                    resp_valid_d = 1'b1;
                    starve_d     = fifo_empty ? '0 : starve_q + STV_W'(1);
                end
            end
            ST_UPD_WR: begin
                en_c    = 1'b1;
                we_c    = 1'b1;
                addr_c  = upd_idx_q;
                wdata_c = sat_val;
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        fifo_idx_d = fifo_idx_q;
        fifo_out_d = fifo_out_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            fifo_idx_d[wr_ptr_q] = fb_idx;
            fifo_out_d[wr_ptr_q] = fb_outcome;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            init_idx_q   <= '0;
            upd_idx_q    <= '0;
            upd_out_q    <= 1'b0;
            starve_q     <= '0;
            resp_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_idx_q[i] <= '0;
                fifo_out_q[i] <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            upd_idx_q    <= upd_idx_d;
            upd_out_q    <= upd_out_d;
            starve_q     <= starve_d;
            resp_valid_q <= resp_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fifo_idx_q   <= fifo_idx_d;
            fifo_out_q   <= fifo_out_d;
        end
    end

    // Keep the port quiet while reset is held; the INIT state alone would drive the index-0 write.
    assign pht_en          = rst_n & en_c;
    assign pht_we          = rst_n & we_c;
    assign pht_addr        = rst_n ? addr_c : '0;
    assign pht_wdata       = rst_n ? wdata_c : 2'b00;
    assign resp_valid      = resp_valid_q;
    assign resp_prediction = resp_valid_q & pht_rdata[1];
endmodule

// File: tb/tb_pht_port_scheduler.sv
// Scoreboarded bench for pht_port_scheduler with a transaction-level model of the
// table, feedback queue and arbitration rules, plus a behavioural SRAM.
module tb_pht_port_scheduler;
    localparam int AW    = 32;
    localparam int IW    = 6;
    localparam int NENT  = 64;
    localparam int DEPTH = 4;
    localparam int SLIM  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_pc = '0;
    logic          req_ready, resp_valid, resp_prediction;
    logic          fb_valid = 1'b0;
    logic [AW-1:0] fb_pc = '0;
    logic          fb_outcome = 1'b0;
    logic          fb_ready, pht_en, pht_we;
    logic [IW-1:0] pht_addr;
    logic [1:0]    pht_wdata;
    logic [1:0]    pht_rdata = 2'b00;

    pht_port_scheduler #(.ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(SLIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_prediction(resp_prediction),
        .fb_valid(fb_valid), .fb_pc(fb_pc), .fb_outcome(fb_outcome), .fb_ready(fb_ready),
        .pht_en(pht_en), .pht_we(pht_we), .pht_addr(pht_addr),
        .pht_wdata(pht_wdata), .pht_rdata(pht_rdata)
    );

    always #5 clk = ~clk;

    logic [1:0] sram [NENT];
    always @(posedge clk) begin
        if (pht_en) begin
            if (pht_we) sram[pht_addr] <= pht_wdata;
            else        pht_rdata <= sram[pht_addr];
        end
    end

    typedef struct { bit we; int addr; int data; } acc_t;
    typedef struct { int cyc; bit pred; } resp_t;
    typedef struct { int idx; bit taken; } fb_t;

    acc_t  exp_acc[$];
    resp_t exp_resp[$];
    fb_t   m_fq[$];
    int    m_pht [NENT];
    int    m_init_cnt = 0;
    bit    m_pend = 0;
    fb_t   m_cur;
    int    m_grants = 0;
    bit    exp_rr = 0, exp_fr = 0;
    int    cyc = 0;
    int    tests = 0, fails = 0;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic flag(input string name, input string detail);
        tests++;
        fails++;
        $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
    endtask

    function automatic int pc_index(input logic [AW-1:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction

    function automatic logic [AW-1:0] mk_pc(input int idx);
        logic [AW-1:0] pc;
        pc = $urandom;
        pc[IW+1:2] = idx[IW-1:0];
        return pc;
    endfunction

    // Expected behaviour of one port cycle, from the table/queue view of the block.
    task automatic model_step(input bit rv, input logic [AW-1:0] rpc,
                              input bit fv, input logic [AW-1:0] fpc, input bit fo);
        int  c, n, ridx;
        bool_waiting: begin end
        ridx   = pc_index(rpc);
        exp_rr = 0;
        exp_fr = 0;
        if (m_init_cnt < NENT) begin
            exp_acc.push_back('{we: 1, addr: m_init_cnt, data: 1});
            m_pht[m_init_cnt] = 1;
            m_init_cnt++;
        end else if (m_pend) begin
            c = m_pht[m_cur.idx];
            n = m_cur.taken ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
            exp_acc.push_back('{we: 1, addr: m_cur.idx, data: n});
            m_pht[m_cur.idx] = n;
            m_pend = 0;
            exp_fr = (m_fq.size() < DEPTH);
        end else begin
            exp_fr = (m_fq.size() < DEPTH);
            if (m_fq.size() > 0 && (!rv || m_grants == SLIM)) begin
                m_cur    = m_fq.pop_front();
                m_pend   = 1;
                m_grants = 0;
                exp_acc.push_back('{we: 0, addr: m_cur.idx, data: 0});
            end else if (rv) begin
                exp_rr = 1;
                exp_acc.push_back('{we: 0, addr: ridx, data: 0});
                exp_resp.push_back('{cyc: cyc + 1, pred: (m_pht[ridx] >= 2)});
                m_grants = (m_fq.size() > 0) ? m_grants + 1 : 0;
            end
        end
        if (fv && exp_fr) m_fq.push_back('{idx: pc_index(fpc), taken: fo});
    endtask

    task automatic model_reset();
        m_init_cnt = 0;
        m_pend     = 0;
        m_grants   = 0;
        m_fq.delete();
        exp_acc.delete();
        exp_resp.delete();
        exp_rr = 0;
        exp_fr = 0;
    endtask

    task automatic drive(input bit rv, input int ridx, input bit fv, input int fidx, input bit fo);
        @(posedge clk);
        #1;
        cyc++;
        rst_n      = 1'b1;
        req_valid  = rv;
        req_pc     = mk_pc(ridx);
        fb_valid   = fv;
        fb_pc      = mk_pc(fidx);
        fb_outcome = fo;
        #1;
        model_step(rv, req_pc, fv, fb_pc, fo);
    endtask

    task automatic reset_cycle();
        @(posedge clk);
        #1;
        cyc++;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        fb_valid  = 1'b0;
        #1;
        model_reset();
    endtask

    task automatic random_cycle(input int req_pct, input int fb_pct);
        drive(($urandom % 100) < req_pct, ($urandom % 4 == 0) ? $urandom % NENT : $urandom % 8,
              ($urandom % 100) < fb_pct, $urandom % 8, $urandom % 2);
    endtask

    // Monitor: compares everything the DUT presents against the queued expectations.
    initial begin
        acc_t  a;
        resp_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_pht_en", pht_en, 0);
                chk("rst_pht_we", pht_we, 0);
                chk("rst_pht_addr", pht_addr, 0);
                chk("rst_pht_wdata", pht_wdata, 0);
                chk("rst_req_ready", req_ready, 0);
                chk("rst_resp_valid", resp_valid, 0);
                chk("rst_resp_prediction", resp_prediction, 0);
                chk("rst_fb_ready", fb_ready, 0);
            end else begin
                chk("req_ready", req_ready, exp_rr);
                chk("fb_ready", fb_ready, exp_fr);
                if (pht_en) begin
                    if (exp_acc.size() == 0) begin
                        flag("pht_unexpected", $sformatf("access we=%0d addr=%0d, none expected", pht_we, pht_addr));
                    end else begin
                        a = exp_acc.pop_front();
                        chk("pht_we", pht_we, a.we);
                        chk("pht_addr", pht_addr, a.addr);
                        if (a.we) chk("pht_wdata", pht_wdata, a.data);
                    end
                end else if (exp_acc.size() != 0) begin
                    flag("pht_missing", $sformatf("no access, expected we=%0d addr=%0d", exp_acc[0].we, exp_acc[0].addr));
                    exp_acc.delete();
                end
                if (resp_valid) begin
                    if (exp_resp.size() == 0) begin
                        flag("resp_unexpected", $sformatf("resp_valid with prediction %0d", resp_prediction));
                    end else begin
                        r = exp_resp.pop_front();
                        chk("resp_cycle", cyc, r.cyc);
                        chk("resp_prediction", resp_prediction, r.pred);
                    end
                end else if (exp_resp.size() != 0 && exp_resp[0].cyc <= cyc) begin
                    flag("resp_missing", $sformatf("expected prediction %0d", exp_resp[0].pred));
                    void'(exp_resp.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int waited;
        reset_cycle();
        reset_cycle();
        // Init with noise on both inputs: nothing may be granted or accepted.
        for (int i = 0; i < NENT; i++) random_cycle(50, 50);
        // Prediction of pc 0x10 (index 4) from a freshly initialised table.
        drive(1, 4, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        // Two TAKEN trainings on index 4, then predict it.
        drive(0, 0, 1, 4, 1);
        drive(0, 0, 1, 4, 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
        drive(1, 4, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        // Four NOT_TAKEN from 11 saturates at 00.
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 4, 0);
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0);
        // Drive index 9 to 11, then TAKEN once more.
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 9, 1);
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0);
        drive(1, 9, 0, 0, 0);
        // Starvation: requests held high, one feedback pushed.
        drive(1, 3, 1, 5, 1);
        for (int i = 0; i < 10; i++) drive(1, 5, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        // Full FIFO: five back-to-back feedbacks under continuous requests.
        for (int i = 0; i < 5; i++) drive(1, i, 1, 10 + i, i % 2);
        for (int i = 0; i < 20; i++) drive(1, 10 + (i % 5), 0, 0, 0);
        for (int i = 0; i < 12; i++) drive(0, 0, 0, 0, 0);
        // Randomised traffic with heavy index reuse.
        for (int i = 0; i < 1500; i++) random_cycle(60, 40);
        // Reset while an update write is due.
        waited = 0;
        while (!m_pend && waited < 200) begin
            random_cycle(30, 80);
            waited++;
        end
        chk("pend_found", m_pend, 1);
        reset_cycle();
        reset_cycle();
        for (int i = 0; i < NENT; i++) random_cycle(40, 40);
        for (int i = 0; i < 400; i++) random_cycle(70, 50);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("acc_queue_drained", exp_acc.size(), 0);
        chk("resp_queue_drained", exp_resp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
